ofdm_symbol_sequencer: RTL and testbench
========================================

Name: ofdm_symbol_sequencer

Overview:
Parametrised control sequencer for the OFDM baseband transmit chain. It replaces the fixed pulse-generator/counter chain with one FSM. The FSM steps each symbol through serial-to-parallel collection, IFFT, cyclic-prefix insertion and parallel-to-serial output. It adds valid/ready handshakes on both sides, multi-symbol frames, abort, and per-sample indices for the datapath blocks.

Parameters:
FFT_SIZE, 8, subcarriers per symbol (>=2)
CP_LEN, 2, cyclic-prefix samples (0..FFT_SIZE)
IFFT_LAT, 5, cycles en_ifft is held per symbol (>=1)
NUM_SYMBOLS, 4, symbols per frame (>=1)
(localparams) SP_W = max(1,$clog2(FFT_SIZE)); PS_W = max(1,$clog2(FFT_SIZE+CP_LEN)); SC_W = max(1,$clog2(NUM_SYMBOLS))

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  begin frame; sampled only in IDLE
abort  in  1  synchronous return to IDLE; highest priority
in_valid  in  1  QPSK sample available
in_ready  out  1  high in COLLECT
en_sp  out  1  in_valid && in_ready; S/P shift strobe
sp_idx  out  SP_W  index of sample accepted this cycle
en_ifft  out  1  high throughout IFFT state
en_cp  out  1  one-cycle CP-insert strobe
load_ps  out  1  one-cycle P/S load strobe
out_valid  out  1  high in SERIAL
out_ready  in  1  downstream accept
en_ps  out  1  out_valid && out_ready; P/S shift strobe
out_idx  out  PS_W  output sample index, 0..FFT_SIZE+CP_LEN-1
sym_cnt  out  SC_W  current symbol within frame
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse after final output handshake

Behaviour:
- rst: state=IDLE. All counters, sp_idx, out_idx and sym_cnt = 0. All outputs 0. This holds even when rst asserts mid-symbol.
- Outputs decode from registered state/counters (Moore). en_sp and en_ps are the only handshake ANDs.
- IDLE: if start && !abort -> COLLECT, sym_cnt=0.
- COLLECT: in_ready=1. Each en_sp increments sp_idx. An en_sp with sp_idx==FFT_SIZE-1 -> IFFT, sp_idx=0. Cycles with in_valid=0 hold everything.
- IFFT: en_ifft=1 for exactly IFFT_LAT cycles (internal counter), then -> CP.
- CP: en_cp=1 for one cycle -> LOAD.
- LOAD: load_ps=1 for one cycle -> SERIAL, out_idx=0.
- SERIAL: out_valid=1. Each en_ps increments out_idx. When out_ready=0, out_idx holds and out_valid stays 1.
- An en_ps with out_idx==FFT_SIZE+CP_LEN-1 ends the symbol:
  - sym_cnt==NUM_SYMBOLS-1: -> IDLE, sym_cnt=0, frame_done=1 next cycle.
  - otherwise: sym_cnt+1 -> COLLECT.
- Unstalled symbol time: FFT_SIZE+IFFT_LAT+2+FFT_SIZE+CP_LEN cycles (defaults: 25).
- in_ready rises the cycle after start is sampled.
- abort in any state: next cycle IDLE, all counters 0, no frame_done. abort+start in the same cycle: abort wins.
- start outside IDLE is ignored.
- in_valid outside COLLECT is ignored (no side effects).
- Counters never wrap past their terminal values.

Optional Feature:
OFDM_SEQ_OVERRUN_EN
- Defined: adds output port overrun (1 bit, reset 0), sticky.
  - Set when in_valid=1 && in_ready=0 && state!=IDLE.
  - Cleared on an accepted start, on abort, or on rst.
- Undefined: the overrun port and its logic are absent; behaviour is otherwise identical.

Test Plan:
1. Defaults, in_valid=1 and out_ready=1 constant, one start pulse -> per symbol: in_ready 8 cycles (sp_idx 0..7), en_ifft 5, en_cp 1, load_ps 1, out_valid 10 (out_idx 0..9). This repeats for sym_cnt 0..3; frame_done pulses once, 100 cycles after in_ready first rises; busy then 0.
2. in_valid toggling 1,0,1,0... in COLLECT -> collection takes 16 cycles; en_sp fires 8 times; sp_idx advances only on accepts.
3. out_ready=0 for 3 cycles at out_idx=4 -> out_idx holds 4, en_ps=0, out_valid=1; resumes at 5; symbol lasts 3 cycles longer.
4. abort during IFFT (cycle 3 of 5) -> next cycle IDLE with all outputs 0 and no frame_done; a following start runs a full frame normally.
5. rst asserted mid-SERIAL (out_idx=6) -> outputs 0 immediately (async); after release, start is required before in_ready rises.
6. OFDM_SEQ_OVERRUN_EN defined, in_valid=1 during IFFT -> overrun=1, held through the frame, cleared by the next accepted start. With the macro undefined, the same stimulus causes no change.

Source files
------------

// File: rtl/ofdm_symbol_sequencer.sv
// OFDM transmit sequencer: steps each symbol through S/P collect, IFFT, CP insert, P/S load and serial output.
// Latency: in_ready rises 1 cycle after start; unstalled symbol = 2*FFT_SIZE+IFFT_LAT+2+CP_LEN cycles.
// Backpressure: in_valid=0 holds collection, out_ready=0 holds serial output; abort returns to IDLE at once.
// Optional build macro OFDM_SEQ_OVERRUN_EN adds the sticky 'overrun' output.
module ofdm_symbol_sequencer #(
    parameter int FFT_SIZE    = 8,
    parameter int CP_LEN      = 2,
    parameter int IFFT_LAT    = 5,
    parameter int NUM_SYMBOLS = 4,
    localparam int SP_W = ($clog2(FFT_SIZE) < 1) ? 1 : $clog2(FFT_SIZE),
    localparam int PS_W = ($clog2(FFT_SIZE + CP_LEN) < 1) ? 1 : $clog2(FFT_SIZE + CP_LEN),
    localparam int SC_W = ($clog2(NUM_SYMBOLS) < 1) ? 1 : $clog2(NUM_SYMBOLS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            en_sp,
    output logic [SP_W-1:0] sp_idx,
    output logic            en_ifft,
    output logic            en_cp,
    output logic            load_ps,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            en_ps,
    output logic [PS_W-1:0] out_idx,
    output logic [SC_W-1:0] sym_cnt,
    output logic            busy,
    output logic            frame_done
`ifdef OFDM_SEQ_OVERRUN_EN
    ,
    output logic            overrun
`endif
);

    localparam int IL_W = ($clog2(IFFT_LAT) < 1) ? 1 : $clog2(IFFT_LAT);

    localparam logic [SP_W-1:0] SP_LAST = SP_W'(FFT_SIZE - 1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(FFT_SIZE + CP_LEN - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(NUM_SYMBOLS - 1);
    localparam logic [IL_W-1:0] IL_LAST = IL_W'(IFFT_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_IFFT,
        S_CP,
        S_LOAD,
        S_SERIAL
    } state_t;

    state_t          state;
    logic [IL_W-1:0] ifft_cnt;

    // Moore decode of the registered state; the two enables are the only handshake ANDs
    assign in_ready  = (state == S_COLLECT);
    assign en_sp     = in_valid && in_ready;
    assign en_ifft   = (state == S_IFFT);
    assign en_cp     = (state == S_CP);
    assign load_ps   = (state == S_LOAD);
    assign out_valid = (state == S_SERIAL);
    assign en_ps     = out_valid && out_ready;
    assign busy      = (state != S_IDLE);

    // Sequencer FSM with its counters; abort overrides every state transition
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            sp_idx     <= '0;
            out_idx    <= '0;
            sym_cnt    <= '0;
            ifft_cnt   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (abort) begin
                state    <= S_IDLE;
                sp_idx   <= '0;
                out_idx  <= '0;
                sym_cnt  <= '0;
                ifft_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state   <= S_COLLECT;
                            sym_cnt <= '0;
                            sp_idx  <= '0;
                        end
                    end
                    S_COLLECT: begin
                        if (en_sp) begin
                            if (sp_idx == SP_LAST) begin
                                sp_idx   <= '0;
                                ifft_cnt <= '0;
                                state    <= S_IFFT;
                            end else begin
                                sp_idx <= sp_idx + SP_W'(1);
                            end
                        end
                    end
                    S_IFFT: begin
                        if (ifft_cnt == IL_LAST) begin
                            ifft_cnt <= '0;
                            state    <= S_CP;
                        end else begin
                            ifft_cnt <= ifft_cnt + IL_W'(1);
                        end
                    end
                    S_CP: begin
                        state <= S_LOAD;
                    end
                    S_LOAD: begin
                        out_idx <= '0;
                        state   <= S_SERIAL;
                    end
                    S_SERIAL: begin
                        if (en_ps) begin
                            if (out_idx == PS_LAST) begin
                                out_idx <= '0;
                                if (sym_cnt == SC_LAST) begin
                                    sym_cnt    <= '0;
                                    frame_done <= 1'b1;
                                    state      <= S_IDLE;
                                end else begin
                                    sym_cnt <= sym_cnt + SC_W'(1);
                                    state   <= S_COLLECT;
                                end
                            end else begin
                                out_idx <= out_idx + PS_W'(1);
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef OFDM_SEQ_OVERRUN_EN
    // Sticky flag for upstream offering data while the sequencer cannot take it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (abort || (state == S_IDLE && start)) begin
            overrun <= 1'b0;
        end else if (in_valid && !in_ready && state != S_IDLE) begin
            overrun <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ofdm_symbol_sequencer.sv
// Bench for ofdm_symbol_sequencer: directed frames, expected strobe events queued and checked by a monitor.
// Latency: frame_done expected 100 cycles after in_ready first rises with defaults.
// Backpressure: in_valid toggling and a 3-cycle out_ready stall are driven by dedicated driver loops.
module tb_ofdm_symbol_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       in_ready, en_sp, en_ifft, en_cp, load_ps, out_valid, en_ps, busy, frame_done;
    logic [2:0] sp_idx;
    logic [3:0] out_idx;
    logic [1:0] sym_cnt;
`ifdef OFDM_SEQ_OVERRUN_EN
    logic       overrun;
`endif

    int checks = 0;
    int failures = 0;

    // event kinds: 0 sp accept, 1 ifft cycle, 2 cp, 3 load, 4 ps accept, 5 frame_done
    typedef struct {
        int k;
        int idx;
        int sym;
    } ev_t;
    ev_t exp_q[$];

    int vmode = 0;   // 0: in_valid=1, 1: toggle 0,1 in COLLECT, 2: in_valid=0
    int omode = 0;   // 0: out_ready=1, 1: one 3-cycle stall at out_idx 4
    int stall_n = 0;

    ofdm_symbol_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .en_sp      (en_sp),
        .sp_idx     (sp_idx),
        .en_ifft    (en_ifft),
        .en_cp      (en_cp),
        .load_ps    (load_ps),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .en_ps      (en_ps),
        .out_idx    (out_idx),
        .sym_cnt    (sym_cnt),
        .busy       (busy),
        .frame_done (frame_done)
`ifdef OFDM_SEQ_OVERRUN_EN
        ,
        .overrun    (overrun)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp_v);
        end
    endtask

    task automatic push_ev(input int k, input int idx, input int sym);
        ev_t e;
        e.k = k;
        e.idx = idx;
        e.sym = sym;
        exp_q.push_back(e);
    endtask

    task automatic push_sym(input int s, input int n_ifft, input bit tail, input int n_ps);
        for (int i = 0; i < 8; i++) push_ev(0, i, s);
        for (int i = 0; i < n_ifft; i++) push_ev(1, 0, s);
        if (tail) begin
            push_ev(2, 0, s);
            push_ev(3, 0, s);
            for (int i = 0; i < n_ps; i++) push_ev(4, i, s);
        end
    endtask

    task automatic push_frame();
        for (int s = 0; s < 4; s++) push_sym(s, 5, 1'b1, 10);
        push_ev(5, 0, 0);
    endtask

    task automatic start_frame();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("in_ready_after_start", int'(in_ready), 1);
    endtask

    task automatic wait_done(output int t);
        t = 0;
        while (!frame_done && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) chk("frame_done_timeout", 0, 1);
    endtask

    // in_valid driver
    initial begin
        bit ph;
        ph = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (vmode)
                0: in_valid = 1'b1;
                1: begin
                    if (in_ready) begin
                        in_valid = ph;
                        ph = ~ph;
                    end else begin
                        in_valid = 1'b0;
                        ph = 1'b0;
                    end
                end
                default: in_valid = 1'b0;
            endcase
        end
    end

    // out_ready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (omode == 1 && out_valid && out_idx == 4'd4 && stall_n < 3) begin
                out_ready = 1'b0;
                stall_n++;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // monitor: every strobe cycle pops one expected event
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                int k;
                int idx;
                int code;
                k = -1;
                idx = 0;
                if (en_sp) begin
                    k = 0;
                    idx = int'(sp_idx);
                end else if (en_ifft) k = 1;
                else if (en_cp) k = 2;
                else if (load_ps) k = 3;
                else if (en_ps) begin
                    k = 4;
                    idx = int'(out_idx);
                end else if (frame_done) k = 5;
                if (k >= 0) begin
                    code = k * 10000 + idx * 100 + int'(sym_cnt);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_event", code, -1);
                    end else begin
                        ev_t e;
                        e = exp_q.pop_front();
                        chk("event", code, e.k * 10000 + e.idx * 100 + e.sym);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int n;
        bit seen;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_en_ifft", int'(en_ifft), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_sp_idx", int'(sp_idx), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_sym_cnt", int'(sym_cnt), 0);
`ifdef OFDM_SEQ_OVERRUN_EN
        chk("rst_overrun", int'(overrun), 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // full frame, no stalls
        vmode = 0;
        omode = 0;
        push_frame();
        start_frame();
        wait_done(t);
        chk("frame_latency", t, 100);
        chk("busy_after_frame", int'(busy), 0);
        @(negedge clk);
        chk("frame_done_single_pulse", int'(frame_done), 0);
`ifdef OFDM_SEQ_OVERRUN_EN
        chk("overrun_set", int'(overrun), 1);
`endif

        // in_valid toggling during collection
        vmode = 1;
        push_frame();
        start_frame();
`ifdef OFDM_SEQ_OVERRUN_EN
        chk("overrun_cleared_by_start", int'(overrun), 0);
`endif
        n = 0;
        while (in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("collect_cycles_toggle", n, 16);
        wait_done(t);

        // 3-cycle out_ready stall at out_idx 4
        vmode = 0;
        omode = 1;
        stall_n = 0;
        push_frame();
        start_frame();
        n = 0;
        while (!out_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        n = 0;
        while (out_valid && n < 100) begin
            n++;
            if (!out_ready) begin
                chk("stall_out_idx", int'(out_idx), 4);
                chk("stall_en_ps", int'(en_ps), 0);
            end
            @(negedge clk);
        end
        chk("serial_cycles_stalled", n, 13);
        wait_done(t);
        omode = 0;

        // abort on the third IFFT cycle
        push_sym(0, 3, 1'b0, 0);
        start_frame();
        n = 0;
        while (!en_ifft && n < 100) begin
            n++;
            @(negedge clk);
        end
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_en_ifft", int'(en_ifft), 0);
        chk("abort_in_ready", int'(in_ready), 0);
        chk("abort_sp_idx", int'(sp_idx), 0);
        seen = 1'b0;
        repeat (3) begin
            seen |= frame_done;
            @(negedge clk);
        end
        chk("abort_no_frame_done", int'(seen), 0);
        push_frame();
        start_frame();
        wait_done(t);
        chk("frame_latency_after_abort", t, 100);

        // reset in the middle of serial output
        push_sym(0, 5, 1'b1, 6);
        start_frame();
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(out_valid && out_idx == 4'd6) && n < 100);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_out_idx", int'(out_idx), 0);
        chk("midrst_in_ready", int'(in_ready), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (in_ready || busy) n++;
        end
        chk("idle_until_start", n, 0);
        vmode = 2;
        start_frame();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_from_collect_busy", int'(busy), 0);

        @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
